// File: rtl/perceptron_pkg.sv
// ----------------------------------------------------------------------------
// perceptron_pkg : shared states, defaults and index-width helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package perceptron_pkg;

    localparam int PX_SIZE_DEF    = 8;
    localparam int INPUT_SIZE_DEF = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        EVAL  = 3'd3,
        OUT   = 3'd4
    } pl_state_e;

    // Neuron index width; a single-neuron layer still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/perceptron_layer_ctrl_if.sv
// ----------------------------------------------------------------------------
// perceptron_layer_ctrl_if : input/output streams, weight-memory and perceptron hookup
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface perceptron_layer_ctrl_if #(
    parameter int INPUT_SIZE  = perceptron_pkg::INPUT_SIZE_DEF,
    parameter int PX_SIZE     = perceptron_pkg::PX_SIZE_DEF,
    parameter int NUM_NEURONS = 4
);
    localparam int IDX_W = perceptron_pkg::idx_width(NUM_NEURONS);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [INPUT_SIZE-1:0][PX_SIZE-1:0]    in_vec;

    logic                                  w_rd_en;
    logic [IDX_W-1:0]                      w_addr;
    logic [INPUT_SIZE:0][PX_SIZE-1:0]      w_data;

    logic [INPUT_SIZE-1:0][PX_SIZE-1:0]    pc_img;
    logic [INPUT_SIZE-1:0][PX_SIZE-1:0]    pc_weights;
    logic [PX_SIZE-1:0]                    pc_bias;
    logic [PX_SIZE-1:0]                    pc_result;

    logic                                  out_valid;
    logic                                  out_ready;
    logic [PX_SIZE-1:0]                    out_data;
    logic [IDX_W-1:0]                      out_idx;
    logic                                  out_last;

    logic                                  busy;

    modport ctrl (
        input  in_valid, in_vec, w_data, pc_result, out_ready,
        output in_ready, w_rd_en, w_addr, pc_img, pc_weights, pc_bias,
               out_valid, out_data, out_idx, out_last, busy
    );

    modport env (
        output in_valid, in_vec, w_data, pc_result, out_ready,
        input  in_ready, w_rd_en, w_addr, pc_img, pc_weights, pc_bias,
               out_valid, out_data, out_idx, out_last, busy
    );

endinterface

`default_nettype wire

// File: rtl/perceptron_layer_ctrl.sv
// ----------------------------------------------------------------------------
// perceptron_layer_ctrl : sequences one combinational perceptron over NUM_NEURONS
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module perceptron_layer_ctrl
    import perceptron_pkg::*;
#(
    parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
    parameter int PX_SIZE     = PX_SIZE_DEF,
    parameter int NUM_NEURONS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    perceptron_layer_ctrl_if.ctrl   bus
);

    localparam int               IDX_W    = idx_width(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    pl_state_e                           state_q,  state_d;
    logic [IDX_W-1:0]                    idx_q,    idx_d;
    logic [INPUT_SIZE-1:0][PX_SIZE-1:0]  img_q,    img_d;
    logic [INPUT_SIZE-1:0][PX_SIZE-1:0]  wts_q,    wts_d;
    logic [PX_SIZE-1:0]                  bias_q,   bias_d;
    logic [PX_SIZE-1:0]                  odata_q,  odata_d;
    logic [IDX_W-1:0]                    oidx_q,   oidx_d;
    logic                                olast_q,  olast_d;
    logic                                ovalid_q, ovalid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            img_q    <= '0;
            wts_q    <= '0;
            bias_q   <= '0;
            odata_q  <= '0;
            oidx_q   <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            img_q    <= img_d;
            wts_q    <= wts_d;
            bias_q   <= bias_d;
            odata_q  <= odata_d;
            oidx_q   <= oidx_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        img_d    = img_q;
        wts_d    = wts_q;
        bias_d   = bias_q;
        odata_d  = odata_q;
        oidx_d   = oidx_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    img_d   = bus.in_vec;
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                // Memory word arrives the cycle after the READ strobe.
                wts_d   = bus.w_data[INPUT_SIZE:1];
                bias_d  = bus.w_data[0];
                state_d = EVAL;
            end
            EVAL: begin
                odata_d  = bus.pc_result;
                oidx_d   = idx_q;
                olast_d  = (idx_q == LAST_IDX);
                ovalid_d = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    if (olast_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.w_rd_en    = (state_q == READ);
    assign bus.w_addr     = idx_q;
    assign bus.pc_img     = img_q;
    assign bus.pc_weights = wts_q;
    assign bus.pc_bias    = bias_q;
    assign bus.out_valid  = ovalid_q;
    assign bus.out_data   = odata_q;
    assign bus.out_idx    = oidx_q;
    assign bus.out_last   = olast_q;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_layer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_perceptron_layer_ctrl : scoreboard bench with stub perceptron and stub weight ROM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_perceptron_layer_ctrl;

    localparam int IS = 5;
    localparam int PX = 8;
    localparam int NN = 4;

    typedef logic [IS-1:0][PX-1:0] vec_t;
    typedef logic [IS:0][PX-1:0]   word_t;

    typedef struct {
        logic [PX-1:0] data;
        logic [1:0]    idx;
        logic          last;
        vec_t          img;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic stub_mode;
    int   vecs = 0;
    int   miss = 0;
    int   cyc  = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perceptron_layer_ctrl_if #(.INPUT_SIZE(IS), .PX_SIZE(PX), .NUM_NEURONS(NN)) bus ();
    perceptron_layer_ctrl_if #(.INPUT_SIZE(IS), .PX_SIZE(PX), .NUM_NEURONS(1))  bus1 ();

    perceptron_layer_ctrl #(.INPUT_SIZE(IS), .PX_SIZE(PX), .NUM_NEURONS(NN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    perceptron_layer_ctrl #(.INPUT_SIZE(IS), .PX_SIZE(PX), .NUM_NEURONS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Weight ROM word for neuron n: bias 0x10+n, first two weights 0x0F.
    function automatic word_t rom_word(input int n);
        word_t w;
        w[0] = 8'h10 + PX'(n);
        w[1] = 8'h0F;
        w[2] = 8'h0F;
        w[3] = PX'(n);
        w[4] = 8'h55;
        w[5] = 8'hC3;
        return w;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < IS; i++) v[i] = PX'($urandom);
        return v;
    endfunction

    always @(posedge clk) if (bus.w_rd_en)  bus.w_data  <= rom_word(int'(bus.w_addr));
    always @(posedge clk) if (bus1.w_rd_en) bus1.w_data <= rom_word(int'(bus1.w_addr));

    assign bus.pc_result  = stub_mode ? (bus.pc_weights[1] ^ bus.pc_img[0]) : bus.pc_bias;
    assign bus1.pc_result = bus1.pc_bias;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input vec_t img, input logic [PX-1:0] data, input int c);
        exp_t e;
        e.data = data;
        e.idx  = 2'(n);
        e.last = (n == NN - 1);
        e.img  = img;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!bus.in_ready && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    // Scoreboard monitor for the 4-neuron layer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(mon_e.data));
                chk("out_idx",  64'(bus.out_idx),  64'(mon_e.idx));
                chk("out_last", 64'(bus.out_last), 64'(mon_e.last));
                chk("pc_img",   64'(bus.pc_img),   64'(mon_e.img));
                if (mon_e.cyc >= 0) chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Monitor for the single-neuron layer.
    int n1 = 0;
    int acc1 = 0;
    int last_acc = -1;
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            chk("nn1_idx",  64'(bus1.out_idx),  64'd0);
            chk("nn1_last", 64'(bus1.out_last), 64'd1);
            chk("nn1_data", 64'(bus1.out_data), 64'h10);
            n1++;
        end
        if (rst_n && bus1.in_valid && bus1.in_ready) begin
            if (last_acc >= 0) chk("nn1_spacing", 64'(cyc - last_acc), 64'd5);
            last_acc = cyc;
            acc1++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t va, vb, vc, v0, v1, vd, ve;
        int   c0;
        int   k;

        rst_n          = 1'b0;
        stub_mode      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_vec     = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_vec    = '0;
        bus1.out_ready = 1'b1;
        repeat (3) step();

        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_w_rd_en",   64'(bus.w_rd_en),   64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_pc_img",    64'(bus.pc_img),    64'd0);
        rst_n = 1'b1;
        step();

        // Basic pass, bias stub, latency checks.
        va = rand_vec();
        bus.in_valid = 1'b1;
        bus.in_vec   = va;
        c0 = cyc;
        for (int n = 0; n < NN; n++) push(n, va, 8'h10 + PX'(n), c0 + 4 + 4 * n);
        step();
        bus.in_valid = 1'b0;
        chk("t1_in_ready_busy", 64'(bus.in_ready), 64'd0);
        chk("t1_w_rd_en",       64'(bus.w_rd_en),  64'd1);
        chk("t1_w_addr",        64'(bus.w_addr),   64'd0);
        chk("t1_busy",          64'(bus.busy),     64'd1);
        drain("t1");
        wait_idle("t1");
        chk("t1_ready_cycle", 64'(cyc), 64'(c0 + 17));

        // Backpressure on neuron 1.
        vb = rand_vec();
        bus.in_valid = 1'b1;
        bus.in_vec   = vb;
        for (int n = 0; n < NN; n++) push(n, vb, 8'h10 + PX'(n), -1);
        step();
        bus.in_valid = 1'b0;
        k = 0;
        while (!(bus.out_valid && bus.out_idx == 2'd1) && k < 50) begin
            step();
            k++;
        end
        chk("t2_reach_n1", 64'(bus.out_valid && bus.out_idx == 2'd1), 64'd1);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t2_hold_data",  64'(bus.out_data),  64'h11);
            chk("t2_hold_idx",   64'(bus.out_idx),   64'd1);
            chk("t2_no_rd",      64'(bus.w_rd_en),   64'd0);
        end
        bus.out_ready = 1'b1;
        drain("t2");
        wait_idle("t2");

        // XOR stub: weight[1] ^ pixel[0].
        stub_mode = 1'b1;
        vc = rand_vec();
        vc[0] = 8'hA5;
        bus.in_valid = 1'b1;
        bus.in_vec   = vc;
        for (int n = 0; n < NN; n++) push(n, vc, 8'hAA, -1);
        step();
        bus.in_valid = 1'b0;
        drain("t3");
        wait_idle("t3");
        stub_mode = 1'b0;

        // in_valid held high across two vectors.
        v0 = rand_vec();
        v1 = rand_vec();
        v1[0] = ~v0[0];
        bus.in_valid = 1'b1;
        bus.in_vec   = v0;
        c0 = cyc;
        for (int n = 0; n < NN; n++) push(n, v0, 8'h10 + PX'(n), c0 + 4 + 4 * n);
        for (int n = 0; n < NN; n++) push(n, v1, 8'h10 + PX'(n), c0 + 21 + 4 * n);
        step();
        bus.in_vec = v1;
        wait_idle("t4a");
        chk("t4_v1_accept_cycle", 64'(cyc), 64'(c0 + 17));
        step();
        bus.in_valid = 1'b0;
        drain("t4");
        wait_idle("t4b");

        // Reset during EVAL of neuron 2.
        vd = rand_vec();
        bus.in_valid = 1'b1;
        bus.in_vec   = vd;
        c0 = cyc;
        for (int n = 0; n < 2; n++) push(n, vd, 8'h10 + PX'(n), c0 + 4 + 4 * n);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        chk("t5_eval_busy",  64'(bus.busy),      64'd1);
        chk("t5_eval_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b0;
        step();
        chk("t5_rst_valid",    64'(bus.out_valid), 64'd0);
        chk("t5_rst_busy",     64'(bus.busy),      64'd0);
        chk("t5_rst_in_ready", 64'(bus.in_ready),  64'd1);
        chk("t5_sb_consumed",  64'(sb.size()),     64'd0);
        rst_n = 1'b1;
        step();
        ve = rand_vec();
        bus.in_valid = 1'b1;
        bus.in_vec   = ve;
        c0 = cyc;
        for (int n = 0; n < NN; n++) push(n, ve, 8'h10 + PX'(n), c0 + 4 + 4 * n);
        step();
        bus.in_valid = 1'b0;
        drain("t5");
        wait_idle("t5");

        // Single-neuron layer, in_valid held high.
        bus1.in_vec   = rand_vec();
        bus1.in_valid = 1'b1;
        repeat (22) step();
        bus1.in_valid = 1'b0;
        repeat (10) step();
        chk("nn1_accepts", 64'(acc1), 64'd5);
        chk("nn1_results", 64'(n1),   64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

`default_nettype wire
